// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-buffer state encoding and per-stage bubble controls.
// The NOP controls deassert every write enable of the stage they belong to.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam logic [3:0] IF_ID_NOP_CTRL  = 4'b0000;
  localparam logic [5:0] ID_EX_NOP_CTRL  = 6'b000000;
  localparam logic [3:0] EX_MEM_NOP_CTRL = 4'b0000;
  localparam logic [2:0] MEM_WB_NOP_CTRL = 3'b000;

endpackage

// File: rtl/pipe_skid_entry.sv
// Holding register for one data+control entry; loads when ld_vld is high.
// Latency 1 cycle; no handshake of its own, the owning stage decides when to load.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int           W       = 72,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_vld,
  input  logic [W-1:0] ld_dat,
  output logic [W-1:0] q_dat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_dat <= RST_VAL;
    end else if (ld_vld) begin
      q_dat <= ld_dat;
    end
  end

endmodule

// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline stage register with valid/ready, flush and NOP bubble insertion; latency 1.
// Backpressure: combinational in_ready_o (1 entry), or registered in_ready_o with skid entry under PIPE_STAGE_SKID_EN.
module pipeline_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 69,
  parameter int                CTRL_W   = 3,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  localparam int ENT_W = DATA_W + CTRL_W;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic              ld_out;
  logic              clr_out;
  logic [ENT_W-1:0]  nxt_dat;

`ifdef PIPE_STAGE_SKID_EN
  stage_state_e     state_q;
  stage_state_e     state_d;
  logic             in_ready_q;
  logic             accept;
  logic             out_xfer;
  logic             ld_skid;
  logic             ld_from_skid;
  logic [ENT_W-1:0] skid_dat;

  assign accept   = in_valid_i & in_ready_q;
  assign out_xfer = out_valid_q & out_ready_i;

  always_comb begin
    state_d      = state_q;
    ld_out       = 1'b0;
    ld_from_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_out      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            ld_out  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && out_xfer) begin
            ld_out = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            ld_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            clr_out = 1'b1;
          end
        end
        ST_FULL: begin
          // Skid drains into the output register on the same edge the output leaves.
          if (out_xfer) begin
            state_d      = ST_ONE;
            ld_out       = 1'b1;
            ld_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  pipe_skid_entry #(
    .W       (ENT_W),
    .RST_VAL ({{DATA_W{1'b0}}, NOP_CTRL})
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .ld_vld (ld_skid),
    .ld_dat ({in_data_i, in_ctrl_i}),
    .q_dat  (skid_dat)
  );

  assign nxt_dat    = ld_from_skid ? skid_dat : {in_data_i, in_ctrl_i};
  assign in_ready_o = in_ready_q;
`else
  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign ld_out     = in_valid_i & in_ready_o;
  assign clr_out    = out_ready_i & ~ld_out;
  assign nxt_dat    = {in_data_i, in_ctrl_i};
`endif

  // Flush keeps the stale datapath bundle; only valid and control are scrubbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= NOP_CTRL;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= NOP_CTRL;
    end else if (ld_out) begin
      out_valid_q              <= 1'b1;
      {out_data_q, out_ctrl_q} <= nxt_dat;
    end else if (clr_out) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= NOP_CTRL;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ctrl_o  = out_ctrl_q;

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Directed bench for pipeline_stage_elastic with a transfer scoreboard; covers base and skid builds.
module tb_pipeline_stage_elastic;

  localparam int                DATA_W = 69;
  localparam int                CTRL_W = 3;
  localparam logic [CTRL_W-1:0] NOP    = 3'b000;
  localparam logic [CTRL_W-1:0] CTL    = 3'b101;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [CTRL_W-1:0] ctl;
  } ent_t;

  ent_t              sb[$];
  logic [DATA_W-1:0] seen[$];
  int                tests = 0;
  int                fails = 0;
  bit                acc;

  always #5 clk = ~clk;

  pipeline_stage_elastic #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .NOP_CTRL (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_ctrl_i   (in_ctrl_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ctrl_o  (out_ctrl_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes with inputs settled, then return #1 after the edge.
  task automatic tick();
    ent_t e;
    acc = 1'b0;
    @(negedge clk);
    if (rst || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("xfer_data", out_data_o, e.dat);
          chk("xfer_ctrl", out_ctrl_o, e.ctl);
        end
        seen.push_back(out_data_o);
      end
      if (in_valid_i && in_ready_o) begin
        e = {in_data_i, in_ctrl_i};
        sb.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  nxt;
    int  cnt;
    bit  exp_rdy;

    rst         = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 'h99;
    in_ctrl_i   = CTL;
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ctrl", out_ctrl_o, NOP);
    chk("rst_data", out_data_o, 0);
    rst        = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("rst_ready", in_ready_o, 1);

    // Streaming pass-through
    seen.delete();
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = DATA_W'(i);
      in_ctrl_i  = CTL;
      tick();
      chk("stream_valid", out_valid_o, 1);
      chk("stream_data", out_data_o, i);
      chk("stream_ctrl", out_ctrl_o, CTL);
    end
    in_valid_i = 1'b0;
    tick();
    chk("stream_end_valid", out_valid_o, 0);
    chk("stream_end_ctrl", out_ctrl_o, NOP);
    chk("stream_count", seen.size(), 8);

    // Backpressure mid-stream
    seen.delete();
    nxt = 1;
    for (int c = 0; c < 10 && nxt <= 3; c++) begin
      in_valid_i = 1'b1;
      in_data_i  = DATA_W'(nxt);
      tick();
      if (acc) nxt++;
    end
    chk("bp_pre_data", out_data_o, 3);
    for (int k = 0; k < 5; k++) begin
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = DATA_W'(nxt);
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = (k == 0);
`else
      exp_rdy = 1'b0;
`endif
      #1;
      chk("bp_in_ready", in_ready_o, exp_rdy);
      tick();
      if (acc) nxt++;
      chk("bp_hold_valid", out_valid_o, 1);
      chk("bp_hold_data", out_data_o, 3);
      chk("bp_hold_ctrl", out_ctrl_o, CTL);
    end
    out_ready_i = 1'b1;
    for (int c = 0; c < 40 && seen.size() < 8; c++) begin
      in_valid_i = (nxt <= 8);
      in_data_i  = DATA_W'(nxt);
      tick();
      if (acc) nxt++;
    end
    in_valid_i = 1'b0;
    chk("bp_drain_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      chk("bp_order", seen[i], i + 1);
    end
    tick();
    chk("bp_end_valid", out_valid_o, 0);

    // Flush with a stalled entry and a simultaneous offer
    seen.delete();
    in_valid_i = 1'b1;
    in_data_i  = 'h6;
    tick();
    in_data_i  = 'h7;
    tick();
    chk("fl_pre_data", out_data_o, 'h7);
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    in_data_i   = 'h8;
    tick();
    chk("fl_valid", out_valid_o, 0);
    chk("fl_ctrl", out_ctrl_o, NOP);
    chk("fl_data_hold", out_data_o, 'h7);
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_after_valid", out_valid_o, 0);
    end
    cnt = 0;
    foreach (seen[i]) if (seen[i] == 'h7 || seen[i] == 'h8) cnt++;
    chk("fl_no_leak", cnt, 0);

    // Single-instruction bubble
    in_valid_i = 1'b1;
    in_data_i  = 'hA;
    in_ctrl_i  = 3'b011;
    tick();
    chk("bub_valid", out_valid_o, 1);
    chk("bub_data", out_data_o, 'hA);
    in_valid_i = 1'b0;
    tick();
    chk("bub_after_valid", out_valid_o, 0);
    chk("bub_after_ctrl", out_ctrl_o, NOP);

    // Reset and flush together
    in_valid_i  = 1'b1;
    in_data_i   = 'hB;
    in_ctrl_i   = CTL;
    out_ready_i = 1'b0;
    tick();
    chk("col_pre_data", out_data_o, 'hB);
    rst     = 1'b1;
    flush_i = 1'b1;
    tick();
    chk("col_valid", out_valid_o, 0);
    chk("col_ctrl", out_ctrl_o, NOP);
    chk("col_data", out_data_o, 0);
    rst        = 1'b0;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("col_ready", in_ready_o, 1);
    chk("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
